pp_mem_arbiter: RTL and testbench
=================================

# pp_mem_arbiter

Two-port arbiter sharing one external memory bus between the fetch stage's instruction port and the memory stage's data port of the pp pipeline. It runs a single outstanding transaction at a time. Under contention it alternates priority between the ports, starting with data after reset. It registers all bus-side outputs, routes the response back to the granted requester, and discards responses for fetch requests withdrawn mid-transaction (flush/branch).

## Interface

- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports

- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- imem_address  in  ADDR_WIDTH  fetch address
- imem_req  in  1  fetch read request, held until imem_ack or withdrawn
- imem_data_out  out  DATA_WIDTH  instruction word, valid with imem_ack
- imem_ack  out  1  one-cycle fetch completion
- dmem_address  in  ADDR_WIDTH  data address
- dmem_data_in  in  DATA_WIDTH  store data
- dmem_data_size  in  2  0 byte, 1 half, 2 word (3 reserved, passed through)
- dmem_read_req  in  1  load request, held until dmem_read_ack
- dmem_write_req  in  1  store request, held until dmem_write_ack
- dmem_data_out  out  DATA_WIDTH  load data, valid with dmem_read_ack
- dmem_read_ack  out  1  one-cycle load completion
- dmem_write_ack  out  1  one-cycle store completion
- m_address  out  ADDR_WIDTH  bus address
- m_data_out  out  DATA_WIDTH  bus write data
- m_data_size  out  2  bus size (2 for fetches)
- m_read_req  out  1  bus read request
- m_write_req  out  1  bus write request
- m_data_in  in  DATA_WIDTH  bus read data
- m_read_ack  in  1  bus read done, data valid
- m_write_ack  in  1  bus write done

## Operation

- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE: a data request is pending if dmem_read_req or dmem_write_req is high. If only one port is pending, grant it. If both are pending, grant the port not granted last (last_grant reset = I, so data wins first).
- Grant: register address, data, size and request type into the m_* outputs. Set last_grant. Go to BUSY_I or BUSY_D.
- Fetch grant: m_read_req=1, m_data_size=2, m_data_out unchanged.
- dmem_read_req and dmem_write_req both high is illegal. It is treated as a write.
- BUSY_x: hold m_* stable until the matching ack (m_read_ack for reads, m_write_ack for writes). On ack: drop m_*_req, capture m_data_in for reads, go to RESP.
- BUSY_I abort: if imem_req is low in any BUSY_I cycle, set the abort flag. The bus transaction still completes, but imem_ack is suppressed in RESP.
- RESP (one cycle): assert the granted requester's ack with its data register, unless aborted. Clear abort. Go to IDLE.
- The non-matching m_*_ack, and any m_*_ack in IDLE or RESP, is ignored.
- imem_data_out and dmem_data_out hold their last captured value between acks.
- m_address, m_data_out and m_data_size hold their last value when idle.

## Timing

- Reset (asynchronous, any state): state=IDLE, last_grant=I, abort=0. All outputs 0, including m_*, *_data_out and all acks. An in-flight bus transaction is abandoned; a late bus ack after reset is ignored.
- Request sampled in IDLE at cycle 0 → m_*_req high from cycle 1.
- m_*_ack sampled at cycle k → m_*_req low and requester ack high at cycle k+1 (RESP) → IDLE at cycle k+2.
- Minimum transaction (bus ack at cycle 1) takes 3 cycles. Back-to-back throughput is 1 transaction per 3 cycles.
- The requester's ack is high exactly one cycle. A request still high in the IDLE cycle after RESP is a new request.
- m_* outputs never change while m_read_req or m_write_req is high.

## Test plan

- Reset: assert reset_n=0 mid BUSY_D, then deassert → all outputs 0 and state IDLE. A bus ack one cycle later produces no requester ack.
- Single fetch: imem_req=1, imem_address=0x100, bus m_read_ack 2 cycles after m_read_req with m_data_in=0x00000013 → m_address=0x100, m_data_size=2. imem_ack pulses once with imem_data_out=0x00000013, 4 cycles after the request was sampled.
- Store: dmem_write_req=1, address 0x2004, data 0xDEADBEEF, size 0 → m_write_req with those values held until m_write_ack. dmem_write_ack pulses one cycle later. dmem_data_out unchanged.
- Contention: imem_req and dmem_read_req held high continuously after reset → grants D, I, D, I… Each ack is delivered to the correct port with the correct data.
- Fetch abort: imem_req dropped during BUSY_I, with m_read_ack later → bus transaction completes and no imem_ack is issued. A following dmem_read_req is granted normally.
- Stray ack: m_write_ack during BUSY_I (read) or in IDLE → ignored, with no state change and no requester ack.

Source files
------------

// File: rtl/pp_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pp_mem_arbiter
// Brief    : Shares one external memory bus between the fetch (I) and the
//            memory-stage (D) ports. One transaction is outstanding at a time.
//            Priority alternates between the ports under contention. All
//            bus-side outputs are registered. A response for a fetch that was
//            withdrawn in flight is dropped.
// Revision : 1.0 - initial release
// ============================================================================
module pp_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    // fetch port
    input  logic [ADDR_WIDTH-1:0] imem_address,
    input  logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_data_out,
    output logic                  imem_ack,
    // data port
    input  logic [ADDR_WIDTH-1:0] dmem_address,
    input  logic [DATA_WIDTH-1:0] dmem_data_in,
    input  logic [1:0]            dmem_data_size,
    input  logic                  dmem_read_req,
    input  logic                  dmem_write_req,
    output logic [DATA_WIDTH-1:0] dmem_data_out,
    output logic                  dmem_read_ack,
    output logic                  dmem_write_ack,
    // external memory bus
    output logic [ADDR_WIDTH-1:0] m_address,
    output logic [DATA_WIDTH-1:0] m_data_out,
    output logic [1:0]            m_data_size,
    output logic                  m_read_req,
    output logic                  m_write_req,
    input  logic [DATA_WIDTH-1:0] m_data_in,
    input  logic                  m_read_ack,
    input  logic                  m_write_ack
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic       GRANT_I   = 1'b0;
    localparam logic       GRANT_D   = 1'b1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  abort_q, abort_d;
    logic [ADDR_WIDTH-1:0] m_address_q, m_address_d;
    logic [DATA_WIDTH-1:0] m_data_out_q, m_data_out_d;
    logic [1:0]            m_data_size_q, m_data_size_d;
    logic                  m_read_req_q, m_read_req_d;
    logic                  m_write_req_q, m_write_req_d;
    logic [DATA_WIDTH-1:0] imem_data_q, imem_data_d;
    logic [DATA_WIDTH-1:0] dmem_data_q, dmem_data_d;
    logic                  imem_ack_q, imem_ack_d;
    logic                  dmem_read_ack_q, dmem_read_ack_d;
    logic                  dmem_write_ack_q, dmem_write_ack_d;

    logic                  w_d_pend;
    logic                  w_grant_d;
    logic                  w_abort;

    // D wins when it is the only requester or when I was granted last
    assign w_d_pend  = dmem_read_req | dmem_write_req;
    assign w_grant_d = w_d_pend & (~imem_req | (last_grant_q == GRANT_I));
    // a withdrawal seen in the ack cycle itself must also suppress the ack
    assign w_abort   = abort_q | ~imem_req;

    // Next-state and registered-output logic
    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        abort_d          = abort_q;
        m_address_d      = m_address_q;
        m_data_out_d     = m_data_out_q;
        m_data_size_d    = m_data_size_q;
        m_read_req_d     = m_read_req_q;
        m_write_req_d    = m_write_req_q;
        imem_data_d      = imem_data_q;
        dmem_data_d      = dmem_data_q;
        imem_ack_d       = 1'b0;
        dmem_read_ack_d  = 1'b0;
        dmem_write_ack_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_grant_d) begin
                    m_address_d   = dmem_address;
                    m_data_out_d  = dmem_data_in;
                    m_data_size_d = dmem_data_size;
                    // read+write together is treated as a write
                    m_write_req_d = dmem_write_req;
                    m_read_req_d  = ~dmem_write_req;
                    last_grant_d  = GRANT_D;
                    state_d       = ST_BUSY_D;
                end else if (imem_req) begin
                    m_address_d   = imem_address;
                    m_data_size_d = SIZE_WORD;
                    m_read_req_d  = 1'b1;
                    m_write_req_d = 1'b0;
                    last_grant_d  = GRANT_I;
                    state_d       = ST_BUSY_I;
                end
            end
            ST_BUSY_I: begin
                abort_d = w_abort;
                if (m_read_ack) begin
                    m_read_req_d = 1'b0;
                    if (!w_abort) begin
                        imem_data_d = m_data_in;
                        imem_ack_d  = 1'b1;
                    end
                    state_d = ST_RESP;
                end
            end
            ST_BUSY_D: begin
                if (m_write_req_q && m_write_ack) begin
                    m_write_req_d    = 1'b0;
                    dmem_write_ack_d = 1'b1;
                    state_d          = ST_RESP;
                end else if (m_read_req_q && m_read_ack) begin
                    m_read_req_d    = 1'b0;
                    dmem_data_d     = m_data_in;
                    dmem_read_ack_d = 1'b1;
                    state_d         = ST_RESP;
                end
            end
            ST_RESP: begin
                abort_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            last_grant_q     <= GRANT_I;
            abort_q          <= 1'b0;
            m_address_q      <= '0;
            m_data_out_q     <= '0;
            m_data_size_q    <= '0;
            m_read_req_q     <= 1'b0;
            m_write_req_q    <= 1'b0;
            imem_data_q      <= '0;
            dmem_data_q      <= '0;
            imem_ack_q       <= 1'b0;
            dmem_read_ack_q  <= 1'b0;
            dmem_write_ack_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            last_grant_q     <= last_grant_d;
            abort_q          <= abort_d;
            m_address_q      <= m_address_d;
            m_data_out_q     <= m_data_out_d;
            m_data_size_q    <= m_data_size_d;
            m_read_req_q     <= m_read_req_d;
            m_write_req_q    <= m_write_req_d;
            imem_data_q      <= imem_data_d;
            dmem_data_q      <= dmem_data_d;
            imem_ack_q       <= imem_ack_d;
            dmem_read_ack_q  <= dmem_read_ack_d;
            dmem_write_ack_q <= dmem_write_ack_d;
        end
    end

    assign m_address      = m_address_q;
    assign m_data_out     = m_data_out_q;
    assign m_data_size    = m_data_size_q;
    assign m_read_req     = m_read_req_q;
    assign m_write_req    = m_write_req_q;
    assign imem_data_out  = imem_data_q;
    assign imem_ack       = imem_ack_q;
    assign dmem_data_out  = dmem_data_q;
    assign dmem_read_ack  = dmem_read_ack_q;
    assign dmem_write_ack = dmem_write_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_pp_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pp_mem_arbiter
// Brief    : Directed self-checking bench for pp_mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pp_mem_arbiter;

    logic        clk;
    logic        reset_n;
    logic [31:0] imem_address;
    logic        imem_req;
    logic [31:0] imem_data_out;
    logic        imem_ack;
    logic [31:0] dmem_address;
    logic [31:0] dmem_data_in;
    logic [1:0]  dmem_data_size;
    logic        dmem_read_req;
    logic        dmem_write_req;
    logic [31:0] dmem_data_out;
    logic        dmem_read_ack;
    logic        dmem_write_ack;
    logic [31:0] m_address;
    logic [31:0] m_data_out;
    logic [1:0]  m_data_size;
    logic        m_read_req;
    logic        m_write_req;
    logic [31:0] m_data_in;
    logic        m_read_ack;
    logic        m_write_ack;

    int n_checks = 0;
    int n_pass   = 0;

    pp_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_address(imem_address), .imem_req(imem_req),
        .imem_data_out(imem_data_out), .imem_ack(imem_ack),
        .dmem_address(dmem_address), .dmem_data_in(dmem_data_in),
        .dmem_data_size(dmem_data_size), .dmem_read_req(dmem_read_req),
        .dmem_write_req(dmem_write_req), .dmem_data_out(dmem_data_out),
        .dmem_read_ack(dmem_read_ack), .dmem_write_ack(dmem_write_ack),
        .m_address(m_address), .m_data_out(m_data_out),
        .m_data_size(m_data_size), .m_read_req(m_read_req),
        .m_write_req(m_write_req), .m_data_in(m_data_in),
        .m_read_ack(m_read_ack), .m_write_ack(m_write_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] all_out;
        reset_n = 1'b0;
        imem_address = '0; imem_req = 1'b0;
        dmem_address = '0; dmem_data_in = '0; dmem_data_size = '0;
        dmem_read_req = 1'b0; dmem_write_req = 1'b0;
        m_data_in = '0; m_read_ack = 1'b0; m_write_ack = 1'b0;
        tick(); tick();
        all_out = {m_address | m_data_out | imem_data_out | dmem_data_out};
        n_checks++;
        if (all_out !== 32'h0 || m_data_size !== 2'd0 || {m_read_req, m_write_req, imem_ack, dmem_read_ack, dmem_write_ack} !== 5'b0)
            $display("FAIL reset_initial: outputs or=%h size=%0d ctl=%b, required all 0", all_out, m_data_size, {m_read_req, m_write_req, imem_ack, dmem_read_ack, dmem_write_ack});
        else n_pass++;
        // start a load, then reset in the middle of it
        reset_n = 1'b1;
        tick();
        dmem_read_req = 1'b1; dmem_address = 32'h0000_0AA0;
        tick();
        n_checks++;
        if (m_read_req !== 1'b1 || m_address !== 32'h0000_0AA0)
            $display("FAIL reset_busy_d_entry: m_read_req=%b m_address=%h, required 1 00000aa0", m_read_req, m_address);
        else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (m_read_req !== 1'b0 || m_address !== 32'h0)
            $display("FAIL reset_async: m_read_req=%b m_address=%h, required 0 00000000", m_read_req, m_address);
        else n_pass++;
        dmem_read_req = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        m_read_ack = 1'b1; m_data_in = 32'h5555_5555;
        tick();
        m_read_ack = 1'b0;
        n_checks++;
        if (dmem_read_ack !== 1'b0 || dmem_data_out !== 32'h0 || imem_ack !== 1'b0)
            $display("FAIL reset_late_ack: dmem_read_ack=%b dmem_data_out=%h imem_ack=%b, required 0 00000000 0", dmem_read_ack, dmem_data_out, imem_ack);
        else n_pass++;
        tick();
        n_checks++;
        if (dmem_read_ack !== 1'b0 || m_read_req !== 1'b0)
            $display("FAIL reset_late_ack2: dmem_read_ack=%b m_read_req=%b, required 0 0", dmem_read_ack, m_read_req);
        else n_pass++;
    endtask

    task automatic test_single_fetch();
        imem_address = 32'h100; imem_req = 1'b1;
        tick();                                   // request sampled here
        n_checks++;
        if (m_read_req !== 1'b1 || m_write_req !== 1'b0 || m_address !== 32'h100 || m_data_size !== 2'd2)
            $display("FAIL fetch_bus: rd=%b wr=%b addr=%h size=%0d, required 1 0 00000100 2", m_read_req, m_write_req, m_address, m_data_size);
        else n_pass++;
        tick();
        tick();
        m_read_ack = 1'b1; m_data_in = 32'h0000_0013;
        tick();
        m_read_ack = 1'b0; m_data_in = 32'hFFFF_FFFF;
        n_checks++;
        if (imem_ack !== 1'b1 || imem_data_out !== 32'h13 || m_read_req !== 1'b0 || dmem_read_ack !== 1'b0)
            $display("FAIL fetch_ack: imem_ack=%b data=%h m_read_req=%b dmem_read_ack=%b, required 1 00000013 0 0", imem_ack, imem_data_out, m_read_req, dmem_read_ack);
        else n_pass++;
        imem_req = 1'b0;
        tick();
        n_checks++;
        if (imem_ack !== 1'b0 || imem_data_out !== 32'h13)
            $display("FAIL fetch_ack_pulse: imem_ack=%b data=%h, required 0 00000013", imem_ack, imem_data_out);
        else n_pass++;
    endtask

    task automatic test_store();
        dmem_write_req = 1'b1; dmem_address = 32'h2004;
        dmem_data_in = 32'hDEAD_BEEF; dmem_data_size = 2'd0;
        tick();
        n_checks++;
        if (m_write_req !== 1'b1 || m_read_req !== 1'b0 || m_address !== 32'h2004 || m_data_out !== 32'hDEAD_BEEF || m_data_size !== 2'd0)
            $display("FAIL store_bus: wr=%b rd=%b addr=%h data=%h size=%0d, required 1 0 00002004 deadbeef 0", m_write_req, m_read_req, m_address, m_data_out, m_data_size);
        else n_pass++;
        // wiggle inputs: the bus side must not move while the request is high
        dmem_address = 32'h9999; dmem_data_in = 32'h0; dmem_data_size = 2'd2;
        tick(); tick();
        n_checks++;
        if (m_write_req !== 1'b1 || m_address !== 32'h2004 || m_data_out !== 32'hDEAD_BEEF || m_data_size !== 2'd0 || dmem_write_ack !== 1'b0)
            $display("FAIL store_hold: wr=%b addr=%h data=%h size=%0d ack=%b, required 1 00002004 deadbeef 0 0", m_write_req, m_address, m_data_out, m_data_size, dmem_write_ack);
        else n_pass++;
        m_write_ack = 1'b1;
        tick();
        m_write_ack = 1'b0;
        n_checks++;
        if (dmem_write_ack !== 1'b1 || m_write_req !== 1'b0 || dmem_data_out !== 32'h0 || dmem_read_ack !== 1'b0)
            $display("FAIL store_ack: ack=%b wr=%b dmem_data_out=%h rd_ack=%b, required 1 0 00000000 0", dmem_write_ack, m_write_req, dmem_data_out, dmem_read_ack);
        else n_pass++;
        dmem_write_req = 1'b0;
        tick();
        n_checks++;
        if (dmem_write_ack !== 1'b0 || m_address !== 32'h2004)
            $display("FAIL store_idle_hold: ack=%b addr=%h, required 0 00002004", dmem_write_ack, m_address);
        else n_pass++;
    endtask

    task automatic test_contention();
        logic [31:0] exp_addr;
        logic [31:0] rdata;
        logic        exp_d;
        apply_reset();
        imem_req = 1'b1; imem_address = 32'h400;
        dmem_read_req = 1'b1; dmem_address = 32'h3000;
        for (int t = 0; t < 4; t++) begin
            exp_d    = (t % 2 == 0);             // D, I, D, I
            exp_addr = exp_d ? 32'h3000 : 32'h400;
            rdata    = 32'hC0DE_0000 + 32'(t);
            tick();
            n_checks++;
            if (m_read_req !== 1'b1 || m_address !== exp_addr)
                $display("FAIL contention_grant%0d: m_read_req=%b addr=%h, required 1 %h", t, m_read_req, m_address, exp_addr);
            else n_pass++;
            m_read_ack = 1'b1; m_data_in = rdata;
            tick();
            m_read_ack = 1'b0;
            n_checks++;
            if (exp_d ? (dmem_read_ack !== 1'b1 || imem_ack !== 1'b0 || dmem_data_out !== rdata)
                      : (imem_ack !== 1'b1 || dmem_read_ack !== 1'b0 || imem_data_out !== rdata))
                $display("FAIL contention_resp%0d: i_ack=%b d_ack=%b i_data=%h d_data=%h, required port %s data %h", t, imem_ack, dmem_read_ack, imem_data_out, dmem_data_out, exp_d ? "D" : "I", rdata);
            else n_pass++;
            tick();
        end
        imem_req = 1'b0; dmem_read_req = 1'b0;
        tick();
    endtask

    task automatic test_fetch_abort();
        imem_req = 1'b1; imem_address = 32'h500;
        tick();
        n_checks++;
        if (m_read_req !== 1'b1 || m_address !== 32'h500)
            $display("FAIL abort_grant: m_read_req=%b addr=%h, required 1 00000500", m_read_req, m_address);
        else n_pass++;
        imem_req = 1'b0;
        tick(); tick();
        m_read_ack = 1'b1; m_data_in = 32'h0000_0BAD;
        tick();
        m_read_ack = 1'b0;
        n_checks++;
        if (imem_ack !== 1'b0 || m_read_req !== 1'b0 || dmem_read_ack !== 1'b0)
            $display("FAIL abort_suppress: imem_ack=%b m_read_req=%b dmem_read_ack=%b, required 0 0 0", imem_ack, m_read_req, dmem_read_ack);
        else n_pass++;
        tick();
        dmem_read_req = 1'b1; dmem_address = 32'h600;
        tick();
        n_checks++;
        if (m_read_req !== 1'b1 || m_address !== 32'h600 || imem_ack !== 1'b0)
            $display("FAIL abort_next_grant: m_read_req=%b addr=%h imem_ack=%b, required 1 00000600 0", m_read_req, m_address, imem_ack);
        else n_pass++;
        m_read_ack = 1'b1; m_data_in = 32'h1234;
        tick();
        m_read_ack = 1'b0;
        n_checks++;
        if (dmem_read_ack !== 1'b1 || dmem_data_out !== 32'h1234 || imem_ack !== 1'b0)
            $display("FAIL abort_next_resp: d_ack=%b data=%h i_ack=%b, required 1 00001234 0", dmem_read_ack, dmem_data_out, imem_ack);
        else n_pass++;
        dmem_read_req = 1'b0;
        tick();
    endtask

    task automatic test_stray_ack();
        m_write_ack = 1'b1; m_read_ack = 1'b1; m_data_in = 32'hAAAA_AAAA;
        tick();
        m_write_ack = 1'b0; m_read_ack = 1'b0;
        tick();
        n_checks++;
        if ({imem_ack, dmem_read_ack, dmem_write_ack, m_read_req, m_write_req} !== 5'b0 || dmem_data_out !== 32'h1234)
            $display("FAIL stray_idle: ctl=%b dmem_data_out=%h, required 00000 00001234", {imem_ack, dmem_read_ack, dmem_write_ack, m_read_req, m_write_req}, dmem_data_out);
        else n_pass++;
        imem_req = 1'b1; imem_address = 32'h700;
        tick();
        m_write_ack = 1'b1;
        tick();
        m_write_ack = 1'b0;
        n_checks++;
        if (m_read_req !== 1'b1 || imem_ack !== 1'b0 || m_address !== 32'h700)
            $display("FAIL stray_busy_i: m_read_req=%b imem_ack=%b addr=%h, required 1 0 00000700", m_read_req, imem_ack, m_address);
        else n_pass++;
        m_read_ack = 1'b1; m_data_in = 32'h77;
        tick();
        m_read_ack = 1'b0;
        n_checks++;
        if (imem_ack !== 1'b1 || imem_data_out !== 32'h77)
            $display("FAIL stray_then_ack: imem_ack=%b data=%h, required 1 00000077", imem_ack, imem_data_out);
        else n_pass++;
        imem_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store();
        test_contention();
        test_fetch_abort();
        test_stray_ack();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
